// File: rtl/branch_ctrl_if.sv
// Request/response handshake between main control and branch_ctrl.
// master: start/opcode/funct out; busy/done/err in. slave: reverse.
interface branch_ctrl_if;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, opcode, funct,
    input  busy, done, err
  );

  modport slave (
    input  start, opcode, funct,
    output busy, done, err
  );
endinterface

// File: rtl/branch_ctrl.sv
// Multicycle control-flow sub-FSM: drives PC-update, ALU and link strobes.
// Ports: clk, reset_n, req (slave handshake), PC/ALU/regfile control outs.
module branch_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  branch_ctrl_if.slave req,
  output logic         PCWrite,
  output logic         PCWriteCond,
  output logic         EQorNE,
  output logic         GTorLT,
  output logic [1:0]   PCSource,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ALUOp,
  output logic [1:0]   RegDst,
  output logic [1:0]   MemtoReg,
  output logic         RegWrite
);

  localparam logic [5:0] OP_RT  = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_BLE = 6'h06;
  localparam logic [5:0] OP_BGT = 6'h07;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BR_CMP = 3'd1,
    JMP    = 3'd2,
    LINK   = 3'd3,
    JR_JMP = 3'd4,
    FIN    = 3'd5
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       pc_write;
    logic       pc_write_cond;
    logic       eq_or_ne;
    logic       gt_or_lt;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
  } ctl_t;

  state_t     state, state_n;
  logic [5:0] opc, opc_n;
  logic [5:0] fn, fn_n;
  logic       errf, errf_n;
  ctl_t       ctl, ctl_n;

  logic is_br, is_j, is_jal, is_jr;

  assign is_br  = req.opcode inside {OP_BEQ, OP_BNE, OP_BLE, OP_BGT};
  assign is_j   = req.opcode == OP_J;
  assign is_jal = req.opcode == OP_JAL;
  assign is_jr  = req.opcode == OP_RT && req.funct == FN_JR;

  always_comb begin
    state_n = state;
    opc_n   = opc;
    fn_n    = fn;
    errf_n  = errf;
    unique case (state)
      IDLE: if (req.start) begin
        opc_n  = req.opcode;
        fn_n   = req.funct;
        errf_n = 1'b0;
        unique case (1'b1)
          is_br:   state_n = BR_CMP;
          is_j:    state_n = JMP;
          is_jal:  state_n = LINK;
          is_jr:   state_n = JR_JMP;
          default: begin
            state_n = FIN;
            errf_n  = 1'b1;
          end
        endcase
      end
      BR_CMP:  state_n = FIN;
      LINK:    state_n = JMP;
      JMP:     state_n = FIN;
      JR_JMP:  state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered: decode the state being entered so the
  // flops present that state's controls during the state itself.
  always_comb begin
    ctl_n      = '0;
    ctl_n.busy = state_n != IDLE;
    unique case (state_n)
      BR_CMP: begin
        ctl_n.alu_src_a     = 1'b1;
        ctl_n.alu_op        = 2'b01;
        ctl_n.pc_write_cond = 1'b1;
        ctl_n.pc_source     = 2'b01;
        ctl_n.eq_or_ne      = opc_n == OP_BNE;
        ctl_n.gt_or_lt      = opc_n == OP_BLE;
      end
      LINK: begin
        ctl_n.reg_dst    = 2'b10;
        ctl_n.mem_to_reg = 2'b10;
        ctl_n.reg_write  = 1'b1;
      end
      JMP: begin
        ctl_n.pc_write  = 1'b1;
        ctl_n.pc_source = 2'b10;
      end
      JR_JMP: begin
        ctl_n.pc_write  = 1'b1;
        ctl_n.pc_source = 2'b11;
      end
      FIN: begin
        ctl_n.done = 1'b1;
        ctl_n.err  = errf_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      opc   <= '0;
      fn    <= '0;
      errf  <= 1'b0;
      ctl   <= '0;
    end else begin
      state <= state_n;
      opc   <= opc_n;
      fn    <= fn_n;
      errf  <= errf_n;
      ctl   <= ctl_n;
    end
  end

  assign req.busy    = ctl.busy;
  assign req.done    = ctl.done;
  assign req.err     = ctl.err;
  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign EQorNE      = ctl.eq_or_ne;
  assign GTorLT      = ctl.gt_or_lt;
  assign PCSource    = ctl.pc_source;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign ALUOp       = ctl.alu_op;
  assign RegDst      = ctl.reg_dst;
  assign MemtoReg    = ctl.mem_to_reg;
  assign RegWrite    = ctl.reg_write;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: per-cycle expected control vectors.
// Stimulus pushes expectations; a forked monitor pops on any activity.
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       PCWrite, PCWriteCond, EQorNE, GTorLT;
  logic [1:0] PCSource, ALUSrcB, ALUOp, RegDst, MemtoReg;
  logic       ALUSrcA, RegWrite;

  branch_ctrl_if bif ();

  branch_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (bif.slave),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .EQorNE      (EQorNE),
    .GTorLT      (GTorLT),
    .PCSource    (PCSource),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {bif.busy, bif.done, bif.err, PCWrite, PCWriteCond,
                EQorNE, GTorLT, PCSource, ALUSrcA, ALUSrcB, ALUOp,
                RegDst, MemtoReg, RegWrite};

  logic [18:0] q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [18:0] mk(
    logic b, logic d, logic e, logic pw, logic pwc, logic eq,
    logic gt, logic [1:0] pcs, logic sa, logic [1:0] sb,
    logic [1:0] aop, logic [1:0] rd, logic [1:0] mtr, logic rw);
    return {b, d, e, pw, pwc, eq, gt, pcs, sa, sb, aop, rd, mtr, rw};
  endfunction

  function automatic logic [18:0] e_br(logic eq, logic gt);
    return mk(1, 0, 0, 0, 1, eq, gt, 2'b01, 1, 2'b00, 2'b01,
              2'b00, 2'b00, 0);
  endfunction

  function automatic logic [18:0] e_jmp();
    return mk(1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00,
              2'b00, 2'b00, 0);
  endfunction

  function automatic logic [18:0] e_jr();
    return mk(1, 0, 0, 1, 0, 0, 0, 2'b11, 0, 2'b00, 2'b00,
              2'b00, 2'b00, 0);
  endfunction

  function automatic logic [18:0] e_link();
    return mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00,
              2'b10, 2'b10, 1);
  endfunction

  function automatic logic [18:0] e_fin(logic e);
    return mk(1, 1, e, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00,
              2'b00, 2'b00, 0);
  endfunction

  task automatic monitor();
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (obs != '0) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output got=%h want=idle", obs);
        end else begin
          e = q.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL cycle_vector got=%h want=%h", obs, e);
          end
        end
      end
    end
  endtask

  task automatic check_zero(string name);
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL %s got=%h want=0", name, obs);
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 of the first IDLE cycle.
  task automatic run(logic [5:0] op, logic [5:0] fn, int n);
    bif.start  = 1'b1;
    bif.opcode = op;
    bif.funct  = fn;
    @(posedge clk);
    #1 bif.start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bif.start  = 1'b0;
    bif.opcode = '0;
    bif.funct  = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 check_zero("reset_state");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    q.push_back(e_br(0, 0)); q.push_back(e_fin(0));
    run(6'h04, 6'h00, 2);
    q.push_back(e_br(1, 0)); q.push_back(e_fin(0));
    run(6'h05, 6'h00, 2);
    q.push_back(e_br(0, 1)); q.push_back(e_fin(0));
    run(6'h06, 6'h00, 2);
    q.push_back(e_br(0, 0)); q.push_back(e_fin(0));
    run(6'h07, 6'h00, 2);
    q.push_back(e_jmp()); q.push_back(e_fin(0));
    run(6'h02, 6'h00, 2);
    q.push_back(e_link()); q.push_back(e_jmp());
    q.push_back(e_fin(0));
    run(6'h03, 6'h00, 3);
    q.push_back(e_jr()); q.push_back(e_fin(0));
    run(6'h00, 6'h08, 2);
    q.push_back(e_fin(1));
    run(6'h00, 6'h20, 1);
    q.push_back(e_fin(1));
    run(6'h3f, 6'h08, 1);
    q.push_back(e_jmp()); q.push_back(e_fin(0));
    run(6'h02, 6'h3f, 2);

    // start pulsed with j during jal's LINK cycle must be ignored
    q.push_back(e_link()); q.push_back(e_jmp());
    q.push_back(e_fin(0));
    bif.start  = 1'b1;
    bif.opcode = 6'h03;
    @(posedge clk);
    #1 bif.opcode = 6'h02;
    @(posedge clk);
    #1 bif.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // asynchronous reset in the middle of LINK aborts jal
    bif.start  = 1'b1;
    bif.opcode = 6'h03;
    @(posedge clk);
    #1 bif.start = 1'b0;
    #1 reset_n = 1'b0;
    q.delete();
    #1 check_zero("reset_abort");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_zero("after_abort_idle");

    q.push_back(e_br(0, 0)); q.push_back(e_fin(0));
    run(6'h04, 6'h00, 2);

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_outputs got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
